// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiply sequencer driving the shared 32-bit ALU
//
// Runs an unsigned WIDTH x WIDTH multiply by borrowing the shared ALU for a few cycles.
// Each cycle it picks the ALU operands and function, and captures ALUOut_in at the clock edge.
//
// Ports:
//   Clock       rising-edge clock
//   Reset       synchronous, active-high reset
//   Start       multiply request, sampled only while idle
//   Op1, Op2    multiplicand / multiplier (WIDTH bits), sampled at the accepting edge
//   Busy        high while the sequencer owns the ALU inputs
//   Done        one-cycle completion pulse
//   Result      32-bit product, zero-extended above 2*WIDTH bits
//   ALU_A/B     ALU operand drive
//   ALU_FunSel  ALU function select
//   ALU_WF      ALU flag-write enable, always 0
//   ALUOut_in   combinational ALU result for the current drive
module alu_mul_sequencer #(
  parameter int           WIDTH       = 16,
  parameter bit           EARLY_EXIT  = 1'b0,
  parameter logic [4:0]   FUNSEL_ADD  = 5'b10100,
  parameter logic [4:0]   FUNSEL_LSL  = 5'b11011,
  parameter logic [4:0]   FUNSEL_IDLE = 5'b10000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  output logic             Busy,
  output logic             Done,
  output logic [31:0]      Result,
  output logic [31:0]      ALU_A,
  output logic [31:0]      ALU_B,
  output logic [4:0]       ALU_FunSel,
  output logic             ALU_WF,
  input  logic [31:0]      ALUOut_in
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [31:0]      acc;
  logic [31:0]      mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      result_q;

  // Bits of the multiplier still to be consumed after the current shift.
  logic [WIDTH-1:0] mplier_rest;
  logic             last_bit;

  assign mplier_rest = mplier >> 1;
  assign last_bit    = (cnt == CNT_LAST) || (EARLY_EXIT && (mplier_rest == '0));

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The first step depends on Op2[0]; later steps on the
  // multiplier bit that becomes the LSB after this shift (mplier[1]).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_next = Op2[0] ? S_ADD : S_SHIFT;
        end
      end
      S_ADD: begin
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_next = S_DONE;
        end else begin
          state_next = mplier[1] ? S_ADD : S_SHIFT;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers. The ALU result is captured into acc (ADD) or
  // mcand (SHIFT); Start outside IDLE is deliberately dropped, not queued.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            acc    <= '0;
            mcand  <= {{(32 - WIDTH){1'b0}}, Op1};
            mplier <= Op2;
            cnt    <= '0;
          end
        end
        S_ADD: begin
          acc <= ALUOut_in;
        end
        S_SHIFT: begin
          mcand  <= ALUOut_in;
          mplier <= mplier_rest;
          cnt    <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          result_q <= acc;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  // Outputs. Result shows acc during DONE so the product is visible in the
  // same cycle as the Done pulse, then holds the registered copy.
  always_comb begin
    Busy       = (state != S_IDLE);
    Done       = (state == S_DONE);
    Result     = (state == S_DONE) ? acc : result_q;
    ALU_WF     = 1'b0;
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_FunSel = FUNSEL_IDLE;
    case (state)
      S_ADD: begin
        ALU_A      = acc;
        ALU_B      = mcand;
        ALU_FunSel = FUNSEL_ADD;
      end
      S_SHIFT: begin
        ALU_A      = mcand;
        ALU_B      = '0;
        ALU_FunSel = FUNSEL_LSL;
      end
      default: begin
        ALU_A      = '0;
        ALU_B      = '0;
        ALU_FunSel = FUNSEL_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - self-checking bench for alu_mul_sequencer with behavioural ALU and product model
module tb_alu_mul_sequencer;

  localparam logic [4:0] F_ADD  = 5'b10100;
  localparam logic [4:0] F_LSL  = 5'b11011;
  localparam logic [4:0] F_IDLE = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: EARLY_EXIT=0, instance 1: EARLY_EXIT=1
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] op1_0 = '0, op2_0 = '0, op1_1 = '0, op2_1 = '0;
  logic        busy0, busy1, done0, done1, wf0, wf1;
  logic [31:0] res0, res1, a0, a1, b0, b1, aluo0, aluo1;
  logic [4:0]  fs0, fs1;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the shared ALU for the three codes the sequencer uses.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fs);
    case (fs)
      F_ADD:   return a + b;
      F_LSL:   return a << 1;
      F_IDLE:  return a;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign aluo0 = alu_model(a0, b0, fs0);
  assign aluo1 = alu_model(a1, b1, fs1);

  alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut (
    .Clock(clk), .Reset(rst), .Start(start0), .Op1(op1_0), .Op2(op2_0),
    .Busy(busy0), .Done(done0), .Result(res0), .ALU_A(a0), .ALU_B(b0),
    .ALU_FunSel(fs0), .ALU_WF(wf0), .ALUOut_in(aluo0)
  );

  alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_ee (
    .Clock(clk), .Reset(rst), .Start(start1), .Op1(op1_1), .Op2(op2_1),
    .Busy(busy1), .Done(done1), .Result(res1), .ALU_A(a1), .ALU_B(b1),
    .ALU_FunSel(fs1), .ALU_WF(wf1), .ALUOut_in(aluo1)
  );

  // Views of whichever instance the current operation targets.
  logic        sel = 1'b0;
  logic        v_busy, v_done, v_wf;
  logic [31:0] v_res;
  logic [4:0]  v_fs;
  always_comb begin
    v_busy = sel ? busy1 : busy0;
    v_done = sel ? done1 : done0;
    v_wf   = sel ? wf1   : wf0;
    v_res  = sel ? res1  : res0;
    v_fs   = sel ? fs1   : fs0;
  end

  function automatic int exp_latency(input bit ee, input logic [15:0] b);
    int msb;
    msb = 0;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
    if (ee) return (msb + 1) + $countones(b) + 1;
    return 17 + $countones(b);
  endfunction

  // Runs one multiply; returns observed latency (-1 on timeout), Result in the
  // Done cycle, Result one cycle later, and per-cycle error counts.
  task automatic run_op(input bit ee, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [31:0] res, output logic [31:0] res_after,
                        output int seq_err, output int wf_err, output int busy_err);
    logic [4:0] exp_q[$];
    bit done_seen;
    exp_q = {};
    for (int i = 0; i < 16; i++) begin
      if (b[i]) exp_q.push_back(F_ADD);
      exp_q.push_back(F_LSL);
      if (ee && ((b >> (i + 1)) == 16'd0)) break;
    end
    exp_q.push_back(F_IDLE);
    seq_err = 0; wf_err = 0; busy_err = 0; lat = 0; res = 'x; done_seen = 1'b0;
    @(negedge clk);
    sel = ee;
    if (ee) begin start1 = 1'b1; op1_1 = a; op2_1 = b; end
    else    begin start0 = 1'b1; op1_0 = a; op2_0 = b; end
    @(posedge clk);
    for (int k = 0; k < 100 && !done_seen; k++) begin
      @(negedge clk);
      if (k == 0) begin start0 = 1'b0; start1 = 1'b0; op1_0 = ~a; op2_0 = ~b; op1_1 = ~a; op2_1 = ~b; end
      lat++;
      if (v_busy !== 1'b1) busy_err++;
      if (v_wf !== 1'b0) wf_err++;
      if (lat > exp_q.size() || v_fs !== exp_q[lat-1]) seq_err++;
      if (v_done === 1'b1) begin res = v_res; done_seen = 1'b1; end
    end
    if (!done_seen) lat = -1;
    @(negedge clk);
    res_after = v_res;
    if (v_busy !== 1'b0 || v_done !== 1'b0) busy_err++;
  endtask

  task automatic check_op(input string name, input bit ee, input logic [15:0] a, input logic [15:0] b);
    int lat, se, we, be, el;
    logic [31:0] r, ra, ep;
    run_op(ee, a, b, lat, r, ra, se, we, be);
    ep = 32'(a) * 32'(b);
    el = exp_latency(ee, b);
    checks++; if (lat !== el) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, el); end
    checks++; if (r !== ep) begin errors++; $display("FAIL %s result: got %h expected %h", name, r, ep); end
    checks++; if (ra !== ep) begin errors++; $display("FAIL %s result_held: got %h expected %h", name, ra, ep); end
    checks++; if (se !== 0) begin errors++; $display("FAIL %s funsel_seq: got %0d bad cycles expected 0", name, se); end
    checks++; if (we !== 0) begin errors++; $display("FAIL %s alu_wf: got %0d bad cycles expected 0", name, we); end
    checks++; if (be !== 0) begin errors++; $display("FAIL %s busy: got %0d bad cycles expected 0", name, be); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", busy0, busy1); end
    checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b expected 00", done0, done1); end
    checks++; if (res0 !== 32'd0 || res1 !== 32'd0) begin errors++; $display("FAIL reset_result: got %h %h expected 0", res0, res1); end
    checks++; if (fs0 !== F_IDLE || fs1 !== F_IDLE) begin errors++; $display("FAIL reset_funsel: got %b %b expected %b", fs0, fs1, F_IDLE); end
    checks++; if (a0 !== 32'd0 || b0 !== 32'd0) begin errors++; $display("FAIL reset_alu_ab: got %h %h expected 0", a0, b0); end
    checks++; if (wf0 !== 1'b0) begin errors++; $display("FAIL reset_wf: got %b expected 0", wf0); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    check_op("mul_3x5", 1'b0, 16'd3, 16'd5);
    check_op("mul_ffff", 1'b0, 16'hFFFF, 16'hFFFF);
    check_op("mul_op2_zero", 1'b0, 16'h1234, 16'h0000);
    check_op("mul_op1_zero", 1'b0, 16'h0000, 16'hA5A5);
  endtask

  task automatic test_early_exit;
    check_op("ee_7x2", 1'b1, 16'd7, 16'd2);
    check_op("ee_op2_zero", 1'b1, 16'h55AA, 16'd0);
    check_op("ee_msb", 1'b1, 16'hFFFF, 16'h8000);
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) & 16'((32'h1 << $urandom_range(16, 1)) - 1);
      check_op($sformatf("rand%0d", i), i[0], a, b);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    bit done_seen;
    logic [31:0] r;
    sel = 1'b0; lat = 0; done_seen = 1'b0; r = '0;
    @(negedge clk); start0 = 1'b1; op1_0 = 16'd3; op2_0 = 16'd5;
    @(posedge clk);
    for (int k = 0; k < 60 && !done_seen; k++) begin
      @(negedge clk);
      lat++;
      start0 = (k == 2);
      if (k == 2) begin op1_0 = 16'd9; op2_0 = 16'd9; end
      if (done0 === 1'b1) begin r = res0; done_seen = 1'b1; end
    end
    start0 = 1'b0;
    checks++; if (lat !== 19 || !done_seen) begin errors++; $display("FAIL ignored_start_latency: got %0d expected 19", lat); end
    checks++; if (r !== 32'h0F) begin errors++; $display("FAIL ignored_start_result: got %h expected 0000000f", r); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ignored_start_not_queued: got busy %b expected 0", busy0); end
    check_op("after_ignored_9x9", 1'b0, 16'd9, 16'd9);
  endtask

  task automatic test_back_to_back;
    int lat;
    bit done_seen;
    logic [31:0] r;
    sel = 1'b0; done_seen = 1'b0; r = '0;
    @(negedge clk); start0 = 1'b1; op1_0 = 16'd3; op2_0 = 16'd5;
    @(posedge clk);
    for (int k = 0; k < 60 && !done_seen; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin r = res0; done_seen = 1'b1; op1_0 = 16'd9; op2_0 = 16'd9; end
    end
    checks++; if (r !== 32'h0F) begin errors++; $display("FAIL b2b_first_result: got %h expected 0000000f", r); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b expected 0", busy0); end
    @(posedge clk);
    lat = 0; done_seen = 1'b0; r = '0;
    for (int k = 0; k < 60 && !done_seen; k++) begin
      @(negedge clk);
      if (k == 0) start0 = 1'b0;
      lat++;
      if (done0 === 1'b1) begin r = res0; done_seen = 1'b1; end
    end
    checks++; if (lat !== 19 || !done_seen) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 19", lat); end
    checks++; if (r !== 32'h51) begin errors++; $display("FAIL b2b_second_result: got %h expected 00000051", r); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int done_cnt;
    sel = 1'b0; done_cnt = 0;
    @(negedge clk); start0 = 1'b1; op1_0 = 16'hFFFF; op2_0 = 16'hFFFF;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0 === 1'b1) done_cnt++;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done0); end
    checks++; if (res0 !== 32'd0) begin errors++; $display("FAIL midreset_result: got %h expected 0", res0); end
    checks++; if (fs0 !== F_IDLE || a0 !== 32'd0 || b0 !== 32'd0) begin errors++; $display("FAIL midreset_alu: got %b %h %h expected %b 0 0", fs0, a0, b0, F_IDLE); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d done/busy cycles expected 0", done_cnt); end
    check_op("after_reset_3x5", 1'b0, 16'd3, 16'd5);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_early_exit();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
